// File: rtl/controller4_alloc.sv
// Wormhole switch allocator for a four-port mesh node. It routes head flits by XY,
// arbitrates round-robin per output, and holds each connection for the whole packet.
`timescale 1ns/1ps
module controller4_alloc #(
    parameter int NODE_X = 0,
    parameter int NODE_Y = 0,
    parameter int DIR_0  = 0,
    parameter int DIR_1  = 1,
    parameter int DIR_2  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      packet_valid,
    input  logic [3:0][7:0] packet_addr,
    input  logic [3:0][7:0] packet_len,
    input  logic [3:0]      buffer_full_in,
    output logic [15:0]     grant,
    output logic [3:0]      pop,
    output logic [3:0]      busy,
    output logic            route_err
);

    localparam logic [3:0] LOC_X      = 4'(NODE_X);
    localparam logic [3:0] LOC_Y      = 4'(NODE_Y);
    localparam logic [1:0] DIR_N      = 2'd0;
    localparam logic [1:0] DIR_S      = 2'd1;
    localparam logic [1:0] DIR_E      = 2'd2;
    localparam logic [1:0] DIR_W      = 2'd3;
    localparam logic [1:0] DIR_OF_P0  = 2'(DIR_0);
    localparam logic [1:0] DIR_OF_P1  = 2'(DIR_1);
    localparam logic [1:0] DIR_OF_P2  = 2'(DIR_2);
    localparam logic [1:0] PORT_LOCAL = 2'd3;

    typedef enum logic [0:0] {OUT_IDLE = 1'b0, OUT_LOCK = 1'b1} out_state_e;
    typedef enum logic [0:0] {IN_PASS  = 1'b0, IN_DROP  = 1'b1} in_state_e;

    // Returns {illegal, port}. Comparisons go through a subtraction so that edge
    // nodes (coordinate 0) do not produce constant-folded compares.
    function automatic logic [2:0] route_lookup(input logic [7:0] addr, input logic [1:0] src);
        logic [4:0] dx;
        logic [4:0] dy;
        logic [1:0] dir;
        logic       is_local;
        logic [2:0] res;
        dx       = {1'b0, addr[3:0]} - {1'b0, LOC_X};
        dy       = {1'b0, addr[7:4]} - {1'b0, LOC_Y};
        dir      = DIR_N;
        is_local = 1'b0;
        if (dx != 5'd0) begin
            dir = dx[4] ? DIR_W : DIR_E;
        end else if (dy != 5'd0) begin
            dir = dy[4] ? DIR_N : DIR_S;
        end else begin
            is_local = 1'b1;
        end
        if (is_local) begin
            res = {1'b0, PORT_LOCAL};
        end else if (dir == DIR_OF_P0) begin
            res = {1'b0, 2'd0};
        end else if (dir == DIR_OF_P1) begin
            res = {1'b0, 2'd1};
        end else if (dir == DIR_OF_P2) begin
            res = {1'b0, 2'd2};
        end else begin
            res = {1'b1, PORT_LOCAL};
        end
        if (res[1:0] == src) begin
            res[2] = 1'b1;
        end else begin
            res[2] = res[2];
        end
        return res;
    endfunction

    // Returns {found, index} of the first requester strictly after last, wrapping.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (req[idx] && !res[2]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] len_load(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

    out_state_e out_state_q [4];
    out_state_e out_state_d [4];
    logic [1:0] win_q       [4];
    logic [1:0] win_d       [4];
    logic [7:0] cnt_q       [4];
    logic [7:0] cnt_d       [4];
    logic [1:0] last_q      [4];
    logic [1:0] last_d      [4];
    in_state_e  in_state_q  [4];
    in_state_e  in_state_d  [4];
    logic [7:0] drop_cnt_q  [4];
    logic [7:0] drop_cnt_d  [4];
    logic       route_err_q;
    logic       route_err_d;

    logic [2:0] route_info_s [4];
    logic [3:0] held_s;
    logic [3:0] head_s;
    logic [3:0] drop_start_s;
    logic [3:0] req_s        [4];
    logic [2:0] pick_s       [4];
    logic [3:0] xfer_s;

    // Route classification, lock status and per-output requests from registered state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            route_info_s[i] = route_lookup(packet_addr[i], 2'(i));
            held_s[i]       = (in_state_q[i] == IN_DROP);
            for (int o = 0; o < 4; o++) begin
                held_s[i] = held_s[i] | ((out_state_q[o] == OUT_LOCK) && (win_q[o] == 2'(i)));
            end
            head_s[i]       = packet_valid[i] & ~held_s[i];
            drop_start_s[i] = head_s[i] & route_info_s[i][2];
        end
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 4; i++) begin
                req_s[o][i] = head_s[i] & ~route_info_s[i][2] & (route_info_s[i][1:0] == 2'(o));
            end
            pick_s[o] = rr_pick(req_s[o], last_q[o]);
            xfer_s[o] = (out_state_q[o] == OUT_LOCK) & packet_valid[win_q[o]] & ~buffer_full_in[o];
        end
    end

    // Per-output next state: lock on the round-robin winner, release on the last flit.
    always_comb begin
        for (int o = 0; o < 4; o++) begin
            out_state_d[o] = out_state_q[o];
            win_d[o]       = win_q[o];
            cnt_d[o]       = cnt_q[o];
            last_d[o]      = last_q[o];
            case (out_state_q[o])
                OUT_IDLE: begin
                    if (pick_s[o][2]) begin
                        out_state_d[o] = OUT_LOCK;
                        win_d[o]       = pick_s[o][1:0];
                        cnt_d[o]       = len_load(packet_len[pick_s[o][1:0]]);
                    end else begin
                        out_state_d[o] = OUT_IDLE;
                    end
                end
                OUT_LOCK: begin
                    if (xfer_s[o] && (cnt_q[o] < 8'd2)) begin
                        out_state_d[o] = OUT_IDLE;
                        last_d[o]      = win_q[o];
                        cnt_d[o]       = 8'd0;
                    end else if (xfer_s[o]) begin
                        cnt_d[o] = cnt_q[o] - 8'd1;
                    end else begin
                        cnt_d[o] = cnt_q[o];
                    end
                end
                default: begin
                    out_state_d[o] = OUT_IDLE;
                end
            endcase
        end
    end

    // Per-input next state: unroutable packets are drained without a grant.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_state_d[i] = in_state_q[i];
            drop_cnt_d[i] = drop_cnt_q[i];
            case (in_state_q[i])
                IN_PASS: begin
                    if (drop_start_s[i]) begin
                        in_state_d[i] = IN_DROP;
                        drop_cnt_d[i] = len_load(packet_len[i]);
                    end else begin
                        in_state_d[i] = IN_PASS;
                    end
                end
                IN_DROP: begin
                    if (packet_valid[i] && (drop_cnt_q[i] < 8'd2)) begin
                        in_state_d[i] = IN_PASS;
                        drop_cnt_d[i] = 8'd0;
                    end else if (packet_valid[i]) begin
                        drop_cnt_d[i] = drop_cnt_q[i] - 8'd1;
                    end else begin
                        drop_cnt_d[i] = drop_cnt_q[i];
                    end
                end
                default: begin
                    in_state_d[i] = IN_PASS;
                end
            endcase
        end
        route_err_d = |drop_start_s;
    end

    // Output FSM registers; last_winner resets to 3 so input 0 is served first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < 4; o++) begin
                out_state_q[o] <= OUT_IDLE;
                win_q[o]       <= 2'd0;
                cnt_q[o]       <= 8'd0;
                last_q[o]      <= 2'd3;
            end
        end else begin
            for (int o = 0; o < 4; o++) begin
                out_state_q[o] <= out_state_d[o];
                win_q[o]       <= win_d[o];
                cnt_q[o]       <= cnt_d[o];
                last_q[o]      <= last_d[o];
            end
        end
    end

    // Input drop FSM registers and the route error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                in_state_q[i] <= IN_PASS;
                drop_cnt_q[i] <= 8'd0;
            end
            route_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                in_state_q[i] <= in_state_d[i];
                drop_cnt_q[i] <= drop_cnt_d[i];
            end
            route_err_q <= route_err_d;
        end
    end

    // Grants and busy follow the lock state; pops also need valid and downstream room.
    always_comb begin
        grant = 16'h0000;
        busy  = 4'b0000;
        pop   = 4'b0000;
        for (int o = 0; o < 4; o++) begin
            busy[o] = (out_state_q[o] == OUT_LOCK);
            for (int i = 0; i < 4; i++) begin
                grant[o*4+i] = (out_state_q[o] == OUT_LOCK) && (win_q[o] == 2'(i));
                pop[i]       = pop[i] | (grant[o*4+i] & xfer_s[o]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop[i] = pop[i] | ((in_state_q[i] == IN_DROP) & packet_valid[i]);
        end
    end

    assign route_err = route_err_q;

endmodule

// File: tb/tb_controller4_alloc.sv
// Bench for controller4_alloc at node (1,1) with ports N,S,E: directed scenarios with
// literal expectations plus random traffic checked against a packet-level model.
`timescale 1ns/1ps
module tb_controller4_alloc;

    localparam int NX = 1;
    localparam int NY = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      packet_valid;
    logic [3:0][7:0] packet_addr;
    logic [3:0][7:0] packet_len;
    logic [3:0]      buffer_full_in;
    logic [15:0]     grant;
    logic [3:0]      pop;
    logic [3:0]      busy;
    logic            route_err;

    int vectors     = 0;
    int miscompares = 0;

    controller4_alloc #(
        .NODE_X(NX), .NODE_Y(NY), .DIR_0(0), .DIR_1(1), .DIR_2(2)
    ) dut (
        .clk(clk), .rst(rst),
        .packet_valid(packet_valid), .packet_addr(packet_addr), .packet_len(packet_len),
        .buffer_full_in(buffer_full_in),
        .grant(grant), .pop(pop), .busy(busy), .route_err(route_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Packet-level model: which output each input owns, flits left, drop status.
    int m_busy [4];
    int m_own  [4];
    int m_rem  [4];
    int m_last [4];
    int m_drop [4];
    int m_drem [4];
    int m_err;

    // Port index for a head flit from input i, or -1 when the packet must be dropped.
    function automatic int route_of(input int i, input logic [7:0] addr);
        int x, y, dir, port;
        x = int'(addr[3:0]);
        y = int'(addr[7:4]);
        if (x > NX)      dir = 2;
        else if (x < NX) dir = 3;
        else if (y > NY) dir = 1;
        else if (y < NY) dir = 0;
        else             dir = -1;
        if (dir == -1)      port = 3;
        else if (dir == 3)  port = -1;
        else                port = dir;
        if (port == i) port = -1;
        return port;
    endfunction

    function automatic int eff_len(input logic [7:0] len);
        return (len == 8'd0) ? 1 : int'(len);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_busy[k] = 0; m_own[k] = 0; m_rem[k] = 0; m_last[k] = 3;
            m_drop[k] = 0; m_drem[k] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_advance();
        int locked [4];
        int was    [4];
        int c;
        int found;
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) locked[i] = m_drop[i];
            for (int o = 0; o < 4; o++) begin
                was[o] = m_busy[o];
                if (m_busy[o] != 0) locked[m_own[o]] = 1;
            end
            m_err = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_drop[i] != 0 && packet_valid[i]) begin
                    m_drem[i]--;
                    if (m_drem[i] == 0) m_drop[i] = 0;
                end
            end
            for (int o = 0; o < 4; o++) begin
                if (was[o] != 0 && packet_valid[m_own[o]] && !buffer_full_in[o]) begin
                    m_rem[o]--;
                    if (m_rem[o] == 0) begin
                        m_busy[o] = 0;
                        m_last[o] = m_own[o];
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (packet_valid[i] && locked[i] == 0 && route_of(i, packet_addr[i]) < 0) begin
                    m_drop[i] = 1;
                    m_drem[i] = eff_len(packet_len[i]);
                    m_err     = 1;
                end
            end
            for (int o = 0; o < 4; o++) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last[o] + k) % 4;
                    if (was[o] == 0 && found == 0 && packet_valid[c] && locked[c] == 0 &&
                        route_of(c, packet_addr[c]) == o) begin
                        found     = 1;
                        m_busy[o] = 1;
                        m_own[o]  = c;
                        m_rem[o]  = eff_len(packet_len[c]);
                    end
                end
            end
        end
    endtask

    initial model_reset();

    logic [15:0] e_grant;
    logic [3:0]  e_busy;
    logic [3:0]  e_pop;

    // Compare process: every cycle, away from the active edge, then step the model.
    always @(negedge clk) begin
        e_grant = 16'h0000;
        e_busy  = 4'b0000;
        e_pop   = 4'b0000;
        for (int o = 0; o < 4; o++) begin
            if (m_busy[o] != 0) begin
                e_grant[o*4 + m_own[o]] = 1'b1;
                e_busy[o]               = 1'b1;
                if (packet_valid[m_own[o]] && !buffer_full_in[o]) e_pop[m_own[o]] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m_drop[i] != 0 && packet_valid[i]) e_pop[i] = 1'b1;
        end
        check("model_grant", grant, e_grant);
        check("model_busy", 16'(busy), 16'(e_busy));
        check("model_pop", 16'(pop), 16'(e_pop));
        check("model_route_err", 16'(route_err), 16'(m_err));
        model_advance();
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst            = 1'b1;
        packet_valid   = 4'b0000;
        buffer_full_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            packet_addr[i] = 8'h00;
            packet_len[i]  = 8'd0;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] g, input logic [3:0] p,
                             input logic [3:0] b, input logic e);
        check({tag, "_grant"}, grant, g);
        check({tag, "_pop"}, 16'(pop), 16'(p));
        check({tag, "_busy"}, 16'(busy), 16'(b));
        check({tag, "_route_err"}, 16'(route_err), 16'(e));
    endtask

    int x, y;
    logic on;

    initial begin
        // Reset held two cycles with every input valid.
        rst            = 1'b0;
        packet_valid   = 4'b1111;
        buffer_full_in = 4'b0000;
        packet_addr[0] = 8'h11; packet_addr[1] = 8'h11; packet_addr[2] = 8'h11; packet_addr[3] = 8'h12;
        for (int i = 0; i < 4; i++) packet_len[i] = 8'd1;
        #6;
        sample();
        check_all("reset", 16'h0000, 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        rst = 1'b1;
        sample();
        check_all("release", 16'h0000, 4'b0000, 4'b0000, 1'b0);
        next_cycle();
        sample();
        check_all("first_grant", 16'h1800, 4'b1001, 4'b1100, 1'b0);
        next_cycle();
        do_reset();

        // Single packet from local port to east, len 3.
        for (int c = 0; c <= 5; c++) begin
            packet_valid[3] = (c <= 3); packet_addr[3] = 8'h12; packet_len[3] = 8'd3;
            sample();
            on = (c >= 1 && c <= 3);
            check_all("single", on ? 16'h0800 : 16'h0000, on ? 4'b1000 : 4'b0000,
                      on ? 4'b0100 : 4'b0000, 1'b0);
            next_cycle();
        end
        do_reset();

        // Same packet with downstream full in cycles 2-3.
        for (int c = 0; c <= 7; c++) begin
            packet_valid[3] = (c <= 5); packet_addr[3] = 8'h12; packet_len[3] = 8'd3;
            buffer_full_in[2] = (c == 2 || c == 3);
            sample();
            on = (c >= 1 && c <= 5);
            check_all("backpressure", on ? 16'h0800 : 16'h0000,
                      (c == 1 || c == 4 || c == 5) ? 4'b1000 : 4'b0000,
                      on ? 4'b0100 : 4'b0000, 1'b0);
            next_cycle();
        end
        do_reset();

        // Three neighbours contend for the local port.
        for (int c = 0; c <= 10; c++) begin
            for (int i = 0; i < 3; i++) begin
                packet_addr[i] = 8'h11; packet_len[i] = 8'd2;
            end
            packet_valid[0] = (c <= 2); packet_valid[1] = (c <= 5); packet_valid[2] = (c <= 8);
            sample();
            if (c == 1 || c == 2)      check_all("contention", 16'h1000, 4'b0001, 4'b1000, 1'b0);
            else if (c == 4 || c == 5) check_all("contention", 16'h2000, 4'b0010, 4'b1000, 1'b0);
            else if (c == 7 || c == 8) check_all("contention", 16'h4000, 4'b0100, 4'b1000, 1'b0);
            else                       check_all("contention", 16'h0000, 4'b0000, 4'b0000, 1'b0);
            next_cycle();
        end
        do_reset();

        // West is absent at this node: packet is drained with a single error pulse.
        for (int c = 0; c <= 4; c++) begin
            packet_valid[3] = (c <= 2); packet_addr[3] = 8'h10; packet_len[3] = 8'd2;
            sample();
            check_all("route_err", 16'h0000, (c == 1 || c == 2) ? 4'b1000 : 4'b0000,
                      4'b0000, (c == 1));
            next_cycle();
        end
        do_reset();

        // Zero length behaves as one flit.
        for (int c = 0; c <= 3; c++) begin
            packet_valid[3] = (c <= 1); packet_addr[3] = 8'h12; packet_len[3] = 8'd0;
            sample();
            check_all("len0", (c == 1) ? 16'h0800 : 16'h0000, (c == 1) ? 4'b1000 : 4'b0000,
                      (c == 1) ? 4'b0100 : 4'b0000, 1'b0);
            next_cycle();
        end
        do_reset();

        // Reset in cycle 2 of a len-5 packet, then a fresh head after release.
        for (int c = 0; c <= 5; c++) begin
            packet_valid[3] = 1'b1; packet_addr[3] = 8'h12; packet_len[3] = 8'd5;
            rst = (c != 2);
            sample();
            on = (c != 0 && c != 3);
            check_all("mid_reset", on ? 16'h0800 : 16'h0000, on ? 4'b1000 : 4'b0000,
                      on ? 4'b0100 : 4'b0000, 1'b0);
            next_cycle();
        end
        do_reset();

        // Random traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 4; i++) begin
                packet_valid[i] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 7) == 0) begin
                    x = int'($urandom_range(0, 15)); y = int'($urandom_range(0, 15));
                end else begin
                    x = int'($urandom_range(0, 2)); y = int'($urandom_range(0, 2));
                end
                packet_addr[i] = {4'(y), 4'(x)};
                packet_len[i]  = ($urandom_range(0, 49) == 0) ? 8'($urandom_range(0, 20))
                                                              : 8'($urandom_range(0, 4));
            end
            for (int o = 0; o < 4; o++) buffer_full_in[o] = ($urandom_range(0, 3) == 0);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controller4_alloc.md
# controller4_alloc

Switch allocator for a 4-interface mesh node: three neighbour ports (0–2) plus local port 3.
- Each cycle it examines the head flit of every input FIFO and computes an XY route.
- It arbitrates round-robin per output port and locks each granted input→output connection for the packet's full flit count (wormhole).
- It drives the per-input FIFO pop strobes and the per-output one-hot mux grants.
- It replaces the per-edge controller variants with a single parameterised block.

## Interface
Parameters:
- NODE_X, 0, node X coordinate (4 bits used); local_addr = {NODE_Y[3:0], NODE_X[3:0]}
- NODE_Y, 0, node Y coordinate (4 bits used)
- DIR_0, 0, compass direction of port 0 (2'd0=N, 1=S, 2=E, 3=W)
- DIR_1, 1, compass direction of port 1
- DIR_2, 2, compass direction of port 2; DIR_0..2 must be distinct

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- packet_valid  in  4  FIFO i head flit valid
- packet_addr  in  4×8  FIFO i head flit destination {Y[7:4], X[3:0]}
- packet_len  in  4×8  FIFO i head flit length field (total flits incl. head)
- buffer_full_in  in  4  downstream of output o cannot accept a flit
- grant  out  16  grant[o*4+i]: input i drives output o; one-hot or zero per o
- pop  out  4  pop FIFO i this cycle (sending_data)
- busy  out  4  output o locked to an input
- route_err  out  1  one-cycle pulse when a packet is dropped

## Operation
- Route (head flits only, i.e. input not locked):
  - dest X > NODE_X → E; dest X < NODE_X → W.
  - Otherwise dest Y > NODE_Y → S; dest Y < NODE_Y → N.
  - Otherwise → local (3).
  - Direction maps to a port through DIR_0..2.
- Illegal route: required direction is absent from DIR_0..2, or resolves to the input's own port (U-turn).
  - The input enters DROP.
  - route_err pulses in the cycle DROP is entered.
  - The input pops packet_len flits whenever packet_valid, ignoring buffer_full_in.
  - No grant is issued during DROP.
- Per-output FSM, IDLE → LOCK → IDLE:
  - IDLE: requesters are valid, unlocked inputs routed to o.
  - Winner is the first requester strictly after last_winner[o], modulo 4. last_winner resets to 3, so input 0 has initial priority.
  - At the clock edge the FSM registers the winner, loads a 8-bit count with packet_len (0 is treated as 1), and goes to LOCK.
  - LOCK: grant[o*4+win]=1 and busy[o]=1.
  - Transfer when packet_valid[win] & ~buffer_full_in[o]: pop[win]=1 and count decrements.
  - A transfer with count==1 returns to IDLE and sets last_winner=win.
- Per-input lock bit:
  - Set when the input wins or enters DROP.
  - Cleared on its final transfer.
  - An input is never granted on two outputs.
- Body flits' addr/len inputs are ignored while locked.
- pop and grant are combinational from registered state and the current valid/full inputs. No pop occurs without valid.

## Timing
- Reset (rst=0 at edge): all FSMs IDLE, counts 0, locks 0, last_winner=3. grant=0, pop=0, busy=0, route_err=0 in the following cycle. Reset mid-packet abandons the packet; the FIFO contents are the FIFO's concern.
- Latency: head valid in cycle t with output idle → grant/busy high in t+1, first pop in t+1 if not full.
- Packet of L flits without backpressure: pops in t+1..t+L; busy low at t+L+1.
- Next packet to the same output: arbitrated in t+L+1 and granted t+L+2. This gives one bubble cycle per packet boundary.
- Backpressure: buffer_full_in[o]=1 holds pop=0 and keeps grant and count unchanged.
- Valid low mid-packet: same as backpressure; the lock is held.
- Simultaneous requests from different inputs to different outputs are all granted in the same cycle.
- route_err is a single-cycle pulse. Two inputs entering DROP in the same cycle produce one pulse.

## Test plan
- Reset: rst=0 for 2 cycles with all packet_valid=1 → grant=0, pop=0, busy=0, route_err=0. After release, the first grant appears 1 cycle later.
- Single packet: NODE=(1,1), DIR=N,S,E; input 3, addr 8'h12, len 3 at cycle 0 → grant[2*4+3]=1 in cycles 1–3, pop[3]=1 in cycles 1–3, busy[2]=0 in cycle 4.
- Contention: inputs 0,1,2 all addr=local_addr, len 2, valid at cycle 0 → served in order 0,1,2. Pops occur in cycles 1–2, 4–5, 7–8, and grant is never two-hot.
- Backpressure: as in the single-packet case, with buffer_full_in[2]=1 in cycles 2–3 → pop[3] in cycles 1,4,5 and grant held in cycles 1–5.
- Route error: DIR=N,S,W (east edge); input 3, dest X=NODE_X+1, len 2 → route_err pulses once, pop[3] for 2 flits, grant stays 0.
- len=0 and reset mid-packet: len=0 packet → exactly one pop. rst=0 at cycle 2 of a len-5 packet → busy=0 next cycle, and a new head is granted normally after release.
